frv_dmem_arbiter: RTL
=====================

// Module: frv_dmem_arbiter
//
// PURPOSE
//  Shares the single core data-memory bus (req/gnt request channel, recv/ack
//  response channel) between two requesters. Port 0 is the memory-stage LSU;
//  port 1 is a secondary master (debug/DMA). Fixed priority to port 0, with a
//  starvation guard for port 1. A small in-order ID FIFO routes each response
//  back to the requester that issued it.
//
// PARAMETERS
//  XLEN        32   data/address width
//  DEPTH       2    max outstanding accepted requests (power of 2, >=2)
//  STARVE_MAX  8    cycles port 1 may lose before it gets priority
//
// PORTS
//  g_clk       in   1      global clock
//  g_reset     in   1      asynchronous, active-high reset
//  cN_req      in   1      port N (N=0,1) request
//  cN_wen      in   1      port N write enable
//  cN_strb     in   4      port N write strobe
//  cN_wdata    in   XLEN   port N write data
//  cN_addr     in   XLEN   port N address
//  cN_gnt      out  1      port N request accepted
//  cN_recv     out  1      port N response valid
//  cN_ack      in   1      port N response accepted
//  cN_error    out  1      port N response error
//  cN_rdata    out  XLEN   port N read data
//  m_req       out  1      bus request
//  m_wen       out  1      bus write enable
//  m_strb      out  4      bus write strobe
//  m_wdata     out  XLEN   bus write data
//  m_addr      out  XLEN   bus address
//  m_gnt       in   1      bus accepted request
//  m_recv      in   1      bus response valid
//  m_ack       out  1      response accepted
//  m_error     in   1      bus response error
//  m_rdata     in   XLEN   bus read data
//
// BEHAVIOUR
//  Reset (async, g_reset=1): ID FIFO empty, count=0, lock clear, starve
//   counter=0. Outputs are combinational from state: with no inputs active,
//   every output is 0.
//  Selection (comb): if lock is set, sel=locked owner. Otherwise sel=1 when
//   c1_req && (!c0_req || starve>=STARVE_MAX), else sel=0.
//  Request channel: m_req = c[sel]_req && !full. m_wen, m_strb, m_wdata and
//   m_addr mux from c[sel]. c[sel]_gnt = m_req && m_gnt; the other gnt is 0.
//   Zero-cycle pass-through, so accept latency = bus latency.
//  Lock: set on (m_req && !m_gnt) and holds sel; clears on m_gnt.
//   - A presented request never changes owner or payload before it is granted.
//   - A requester must hold req and payload stable until gnt.
//  ID FIFO: on m_req && m_gnt, push sel; count+1.
//   - full = (count==DEPTH). While full, m_req=0 even if a pop occurs in the
//     same cycle; the push waits one cycle.
//  Response: head = FIFO head ID. c[head]_recv = m_recv && !empty.
//   - m_ack = c[head]_ack && !empty.
//   - cN_error = m_error and cN_rdata = m_rdata, broadcast to both ports;
//     they are qualified only by cN_recv.
//   - Pop on m_recv && m_ack.
//   - m_recv while empty: protocol violation. m_ack=0; no recv is raised.
//  Push and pop in the same cycle (not full): count unchanged; pointers wrap
//   modulo DEPTH.
//  Starvation counter: increments (saturating at STARVE_MAX) each cycle that
//   c1_req=1 and c1_gnt=0. Clears when c1_gnt=1 or c1_req=0.
//  Reset mid-transaction: outstanding IDs are discarded. Bus-side responses
//   arriving after reset are treated as the empty case.
//
// TESTING
//  1. c0_req & c1_req together, m_gnt=1 -> c0_gnt=1 each cycle. c1_gnt rises
//     on cycle STARVE_MAX+1 (cycle 9). starve then reads 0.
//  2. c1 alone, m_gnt=0 for 3 cycles, then c0_req rises -> m_addr stays
//     c1_addr until m_gnt. Then c1_gnt=1 and the next grant goes to c0.
//  3. DEPTH=2: two grants (IDs 0,1), m_recv=0 -> third request sees m_req=0.
//     m_recv with c0_ack=1 pops; m_req reasserts the next cycle, not the same
//     cycle.
//  4. Responses in order with IDs 1,0, m_rdata=A then B -> c1_recv carries A,
//     then c0_recv carries B. c1_ack=0 holds m_ack=0 and blocks the pop.
//  5. g_reset pulsed with 2 outstanding -> count=0, all gnt/recv/m_req=0
//     immediately. A stray m_recv gives m_ack=0.
//  6. Same-cycle push and pop at count=1 -> count stays 1, ordering preserved
//     across pointer wrap (20 back-to-back alternating transactions).

Source files
------------

// File: rtl/frv_dmem_arbiter.sv
// Two-port arbiter for the core data-memory bus: port 0 wins by default, port 1 is
// protected against starvation, and an in-order ID FIFO steers responses back.
module frv_dmem_arbiter #(
   parameter int unsigned XLEN       = 32,
   parameter int unsigned DEPTH      = 2,
   parameter int unsigned STARVE_MAX = 8
) (
   input  logic            g_clk,
   input  logic            g_reset,

   input  logic            c0_req,
   input  logic            c0_wen,
   input  logic [3:0]      c0_strb,
   input  logic [XLEN-1:0] c0_wdata,
   input  logic [XLEN-1:0] c0_addr,
   output logic            c0_gnt,
   output logic            c0_recv,
   input  logic            c0_ack,
   output logic            c0_error,
   output logic [XLEN-1:0] c0_rdata,

   input  logic            c1_req,
   input  logic            c1_wen,
   input  logic [3:0]      c1_strb,
   input  logic [XLEN-1:0] c1_wdata,
   input  logic [XLEN-1:0] c1_addr,
   output logic            c1_gnt,
   output logic            c1_recv,
   input  logic            c1_ack,
   output logic            c1_error,
   output logic [XLEN-1:0] c1_rdata,

   output logic            m_req,
   output logic            m_wen,
   output logic [3:0]      m_strb,
   output logic [XLEN-1:0] m_wdata,
   output logic [XLEN-1:0] m_addr,
   input  logic            m_gnt,
   input  logic            m_recv,
   output logic            m_ack,
   input  logic            m_error,
   input  logic [XLEN-1:0] m_rdata
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned STV_W = $clog2(STARVE_MAX + 1);

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
   localparam logic [STV_W-1:0] STV_ONE  = STV_W'(1);
   localparam logic [STV_W-1:0] STV_MAX  = STV_W'(STARVE_MAX);

   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_C0   = 2'd1,
      LOCK_C1   = 2'd2
   } lock_t;

   lock_t             r_lockState;
   lock_t             w_lockNext;
   logic [DEPTH-1:0]  r_ids;
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [CNT_W-1:0]  r_count;
   logic [STV_W-1:0]  r_starve;

   logic              w_sel;
   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic              w_head;

   assign w_full  = (r_count == CNT_FULL);
   assign w_empty = (r_count == '0);
   assign w_head  = r_ids[r_rptr];

   // An ungranted request keeps its owner, so payload cannot switch under the bus.
   always_comb begin
      w_sel = 1'b0;
      unique case (r_lockState)
         LOCK_C0: w_sel = 1'b0;
         LOCK_C1: w_sel = 1'b1;
         default: w_sel = c1_req && (!c0_req || (r_starve >= STV_MAX));
      endcase
   end

   always_comb begin
      w_lockNext = r_lockState;
      if (m_gnt) begin
         w_lockNext = LOCK_NONE;
      end else if (m_req) begin
         w_lockNext = w_sel ? LOCK_C1 : LOCK_C0;
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_lockState <= LOCK_NONE;
      end else begin
         r_lockState <= w_lockNext;
      end
   end

   // Full blocks the request even when a pop lands in the same cycle.
   assign m_req   = (w_sel ? c1_req : c0_req) && !w_full;
   assign m_wen   = w_sel ? c1_wen   : c0_wen;
   assign m_strb  = w_sel ? c1_strb  : c0_strb;
   assign m_wdata = w_sel ? c1_wdata : c0_wdata;
   assign m_addr  = w_sel ? c1_addr  : c0_addr;
   assign c0_gnt  = m_req && m_gnt && !w_sel;
   assign c1_gnt  = m_req && m_gnt &&  w_sel;

   assign c0_recv  = m_recv && !w_empty && !w_head;
   assign c1_recv  = m_recv && !w_empty &&  w_head;
   assign m_ack    = (w_head ? c1_ack : c0_ack) && !w_empty;
   assign c0_error = m_error;
   assign c1_error = m_error;
   assign c0_rdata = m_rdata;
   assign c1_rdata = m_rdata;

   assign w_push = m_req && m_gnt;
   assign w_pop  = m_recv && m_ack;

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_ids   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_ids[r_wptr] <= w_sel;
            r_wptr        <= r_wptr + PTR_ONE;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PTR_ONE;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_ONE;
         end else if (!w_push && w_pop) begin
            r_count <= r_count - CNT_ONE;
         end
      end
   end

   // Counts consecutive cycles port 1 waits; saturates so it never wraps back.
   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         r_starve <= '0;
      end else if (c1_req && !c1_gnt) begin
         if (r_starve != STV_MAX) begin
            r_starve <= r_starve + STV_ONE;
         end
      end else begin
         r_starve <= '0;
      end
   end

endmodule
